mul_issue_ctrl: RTL

Sequencer that sits directly upstream and downstream of the Booth multiplier in the ALU datapath. It accepts an operand pair from the datapath, launches one multiply and holds the operands stable while the multiply runs. It then captures the 2*WORD_SIZE product and presents it as HI/LO words for writeback. It also bounds the multiplier latency with a watchdog and buffers one result, so the next operand pair can be issued while the previous result is still waiting.

---
 rtl/mul_issue_ctrl_if.sv | 62 ++++++
 rtl/mul_issue_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_ctrl_if.sv
// mul_issue_ctrl_if
//
// Purpose: bundles every handshake and data signal around the Booth
// multiplier sequencer. This covers the operand intake, the launch/return
// path to the multiplier, the result buffer and the status flags.
//
// Modports:
//   slave  - the sequencer (mul_issue_ctrl) itself.
//   master - its environment: the datapath that supplies operands, the
//            multiplier, and the writeback consumer.
//
// Signal summary:
//   op_valid/op_ready/op_x/op_y         operand pair handshake
//   mul_start/mul_x/mul_y               launch of one multiply
//   mul_done/mul_product                multiplier completion and product
//   res_valid/res_ready/res_hi/res_lo   buffered result handshake
//   timeout                             sticky watchdog flag
//   busy                                sequencer not idle
interface mul_issue_ctrl_if #(
  parameter int WORD_SIZE = 32
);

  logic                     op_valid;
  logic                     op_ready;
  logic [WORD_SIZE-1:0]     op_x;
  logic [WORD_SIZE-1:0]     op_y;

  logic                     mul_start;
  logic [WORD_SIZE-1:0]     mul_x;
  logic [WORD_SIZE-1:0]     mul_y;
  logic                     mul_done;
  logic [2*WORD_SIZE-1:0]   mul_product;

  logic                     res_valid;
  logic                     res_ready;
  logic [WORD_SIZE-1:0]     res_hi;
  logic [WORD_SIZE-1:0]     res_lo;

  logic                     timeout;
  logic                     busy;

  modport slave (
    input  op_valid, op_x, op_y,
    input  mul_done, mul_product,
    input  res_ready,
    output op_ready,
    output mul_start, mul_x, mul_y,
    output res_valid, res_hi, res_lo,
    output timeout, busy
  );

  modport master (
    output op_valid, op_x, op_y,
    output mul_done, mul_product,
    output res_ready,
    input  op_ready,
    input  mul_start, mul_x, mul_y,
    input  res_valid, res_hi, res_lo,
    input  timeout, busy
  );

endinterface

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl
//
// Purpose: sequencer wrapped around the Booth multiplier. It accepts one
// signed operand pair, launches a single multiply with a one-cycle
// mul_start pulse and holds the operands steady until mul_done. It then
// buffers the 2*WORD_SIZE product as HI/LO words for writeback. One extra
// product can be parked internally (STALL) while the result buffer still
// waits for its consumer. A watchdog gives up on a multiply that has not
// completed within MAX_LAT cycles of mul_start and raises a sticky timeout
// flag.
//
// Ports:
//   clk   - system clock, rising edge
//   clr   - asynchronous active-low reset
//   bus   - mul_issue_ctrl_if.slave (operand, multiplier, result, status)
//
// Parameters:
//   WORD_SIZE - operand width (product is 2*WORD_SIZE)
//   MAX_LAT   - cycles from mul_start allowed for mul_done (>= 2)
//
// Build option:
//   MUL_ZERO_BYPASS_EN - when defined, a pair with a zero operand skips the
//   multiplier and produces a zero result directly from IDLE.
module mul_issue_ctrl #(
  parameter int WORD_SIZE = 32,
  parameter int MAX_LAT   = 40
) (
  input  logic            clk,
  input  logic            clr,
  mul_issue_ctrl_if.slave bus
);

  localparam int PW = 2 * WORD_SIZE;
  localparam int CW = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] WDOG_LAST = CW'(MAX_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    STALL
  } state_t;

  state_t               state_q;
  state_t               state_n;

  logic [WORD_SIZE-1:0] x_q;
  logic [WORD_SIZE-1:0] y_q;
  logic [WORD_SIZE-1:0] hi_q;
  logic [WORD_SIZE-1:0] lo_q;
  logic                 res_valid_q;
  logic                 timeout_q;
  logic [PW-1:0]        held_q;
  logic [CW-1:0]        wdog_q;
  logic [CW-1:0]        wdog_n;

  logic                 accept;
  logic                 buf_free;
  logic                 load_res;
  logic [PW-1:0]        load_val;
  logic                 hold_load;
  logic [PW-1:0]        hold_val;
  logic                 timeout_set;

  // Next-state logic. The result buffer counts as free when it is empty or
  // is being drained this very cycle, so back-to-back results never bubble.
  // In WAIT a completing multiply wins over the watchdog on the last
  // allowed cycle.
  always_comb begin
    state_n     = state_q;
    wdog_n      = wdog_q;
    accept      = 1'b0;
    load_res    = 1'b0;
    load_val    = '0;
    hold_load   = 1'b0;
    hold_val    = bus.mul_product;
    timeout_set = 1'b0;
    buf_free    = !res_valid_q || bus.res_ready;

    case (state_q)
      IDLE: begin
        if (bus.op_valid) begin
          accept = 1'b1;
`ifdef MUL_ZERO_BYPASS_EN
          // A zero operand makes the product zero, so skip the multiplier
          // and deliver (or park) a zero result directly.
          if ((bus.op_x == '0) || (bus.op_y == '0)) begin
            if (buf_free) begin
              load_res = 1'b1;
              load_val = '0;
            end else begin
              hold_load = 1'b1;
              hold_val  = '0;
              state_n   = STALL;
            end
          end else begin
            state_n = ISSUE;
          end
`else
          state_n = ISSUE;
`endif
        end
      end

      ISSUE: begin
        wdog_n  = '0;
        state_n = WAIT;
      end

      WAIT: begin
        if (bus.mul_done) begin
          if (buf_free) begin
            load_res = 1'b1;
            load_val = bus.mul_product;
          end else begin
            hold_load = 1'b1;
            hold_val  = bus.mul_product;
          end
          state_n = buf_free ? IDLE : STALL;
        end else if (wdog_q == WDOG_LAST) begin
          timeout_set = 1'b1;
          state_n     = IDLE;
        end else begin
          wdog_n = wdog_q + CW'(1);
        end
      end

      STALL: begin
        // The buffer is always occupied here; it frees when res_ready is seen.
        if (bus.res_ready) begin
          load_res = 1'b1;
          load_val = held_q;
          state_n  = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // FSM state, watchdog and the sticky timeout flag.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= IDLE;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_n;
      wdog_q  <= wdog_n;
      if (timeout_set) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // Operand latch: captured once at acceptance and left untouched until the
  // next acceptance, which keeps mul_x/mul_y stable through the multiply.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      x_q <= '0;
      y_q <= '0;
    end else if (accept) begin
      x_q <= bus.op_x;
      y_q <= bus.op_y;
    end
  end

  // Result buffer plus the single parked product used by STALL. A load in
  // the same cycle as a transfer keeps res_valid high with the new data.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      res_valid_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      held_q      <= '0;
    end else begin
      if (load_res) begin
        res_valid_q <= 1'b1;
        hi_q        <= load_val[PW-1:WORD_SIZE];
        lo_q        <= load_val[WORD_SIZE-1:0];
      end else if (res_valid_q && bus.res_ready) begin
        res_valid_q <= 1'b0;
      end
      if (hold_load) begin
        held_q <= hold_val;
      end
    end
  end

  assign bus.op_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.mul_start = (state_q == ISSUE);
  assign bus.mul_x     = x_q;
  assign bus.mul_y     = y_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_hi    = hi_q;
  assign bus.res_lo    = lo_q;
  assign bus.timeout   = timeout_q;

endmodule
